menshen_ctrl_data_sched: RTL and testbench



---
 rtl/menshen_ctrl_data_sched.sv | 138 +++++++++++++
 tb/tb_menshen_ctrl_data_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/menshen_ctrl_data_sched.sv
// Packet-level arbiter merging the control/reconfiguration stream and the H2C data
// stream onto the single Menshen pipeline input; control wins, bounded by a burst limit.
module menshen_ctrl_data_sched #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int MAX_CTRL_BURST       = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_data_axis_tdata,
  input  logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   s_data_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_data_axis_tuser,
  input  logic                                 s_data_axis_tvalid,
  output logic                                 s_data_axis_tready,
  input  logic                                 s_data_axis_tlast,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_ctrl_axis_tdata,
  input  logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   s_ctrl_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_ctrl_axis_tuser,
  input  logic                                 s_ctrl_axis_tvalid,
  output logic                                 s_ctrl_axis_tready,
  input  logic                                 s_ctrl_axis_tlast,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic                                 m_axis_tsrc,

  input  logic                                 data_pause,
  output logic                                 busy,
  output logic [CNT_WIDTH-1:0]                 ctrl_pkt_cnt,
  output logic [CNT_WIDTH-1:0]                 data_pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_CTRL = 2'd1,
    GNT_DATA = 2'd2
  } state_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_CTRL_BURST);

  state_e               state_q, state_d;
  logic [3:0]           burst_q, burst_d;
  logic [CNT_WIDTH-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d;

  logic data_ok;
  logic ctrl_done;
  logic data_done;

  assign data_ok   = s_data_axis_tvalid & ~data_pause;
  assign ctrl_done = (state_q == GNT_CTRL) & s_ctrl_axis_tvalid & m_axis_tready & s_ctrl_axis_tlast;
  assign data_done = (state_q == GNT_DATA) & s_data_axis_tvalid & m_axis_tready & s_data_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      ctrl_cnt_q <= '0;
      data_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      ctrl_cnt_q <= ctrl_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  // Control yields only when the burst limit is hit and data could actually be granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s_ctrl_axis_tvalid && !((burst_q >= MaxBurst) && data_ok)) state_d = GNT_CTRL;
        else if (data_ok)                                             state_d = GNT_DATA;
      end
      GNT_CTRL: if (ctrl_done) state_d = IDLE;
      GNT_DATA: if (data_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    burst_d    = burst_q;
    ctrl_cnt_d = ctrl_cnt_q;
    data_cnt_d = data_cnt_q;
    if (ctrl_done) begin
      ctrl_cnt_d = ctrl_cnt_q + CNT_WIDTH'(1);
      if (!s_data_axis_tvalid)   burst_d = '0;
      else if (burst_q != 4'hF)  burst_d = burst_q + 4'd1;
    end
    if (data_done) begin
      data_cnt_d = data_cnt_q + CNT_WIDTH'(1);
      burst_d    = '0;
    end
  end

  always_comb begin
    m_axis_tdata       = '0;
    m_axis_tkeep       = '0;
    m_axis_tuser       = '0;
    m_axis_tvalid      = 1'b0;
    m_axis_tlast       = 1'b0;
    s_ctrl_axis_tready = 1'b0;
    s_data_axis_tready = 1'b0;
    case (state_q)
      GNT_CTRL: begin
        m_axis_tdata       = s_ctrl_axis_tdata;
        m_axis_tkeep       = s_ctrl_axis_tkeep;
        m_axis_tuser       = s_ctrl_axis_tuser;
        m_axis_tvalid      = s_ctrl_axis_tvalid;
        m_axis_tlast       = s_ctrl_axis_tlast;
        s_ctrl_axis_tready = m_axis_tready;
      end
      GNT_DATA: begin
        m_axis_tdata       = s_data_axis_tdata;
        m_axis_tkeep       = s_data_axis_tkeep;
        m_axis_tuser       = s_data_axis_tuser;
        m_axis_tvalid      = s_data_axis_tvalid;
        m_axis_tlast       = s_data_axis_tlast;
        s_data_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign m_axis_tsrc  = (state_q == GNT_CTRL);
  assign busy         = (state_q != IDLE);
  assign ctrl_pkt_cnt = ctrl_cnt_q;
  assign data_pkt_cnt = data_cnt_q;

endmodule

// File: tb/tb_menshen_ctrl_data_sched.sv
// Bench for menshen_ctrl_data_sched: vector table, directed corner sequences and
// randomized traffic checked against a packet-level reference model.
module tb_menshen_ctrl_data_sched;
  localparam int DW   = 512;
  localparam int KW   = DW / 8;
  localparam int UW   = 128;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data_axis_tdata = '0, s_ctrl_axis_tdata = '0;
  logic [KW-1:0] s_data_axis_tkeep = '0, s_ctrl_axis_tkeep = '0;
  logic [UW-1:0] s_data_axis_tuser = '0, s_ctrl_axis_tuser = '0;
  logic s_data_axis_tvalid = 1'b0, s_ctrl_axis_tvalid = 1'b0;
  logic s_data_axis_tlast = 1'b0, s_ctrl_axis_tlast = 1'b0;
  logic s_data_axis_tready, s_ctrl_axis_tready;
  logic m_axis_tready = 1'b1;
  logic data_pause = 1'b0;

  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tsrc, busy;
  logic [31:0] ctrl_pkt_cnt, data_pkt_cnt;

  logic [DW-1:0] w_tdata;
  logic [KW-1:0] w_tkeep;
  logic [UW-1:0] w_tuser;
  logic w_tvalid, w_tlast, w_tsrc, w_busy, w_d_tready, w_c_tready;
  logic [3:0] w_ccnt, w_dcnt;

  menshen_ctrl_data_sched #(.MAX_CTRL_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .s_data_axis_tdata(s_data_axis_tdata), .s_data_axis_tkeep(s_data_axis_tkeep),
    .s_data_axis_tuser(s_data_axis_tuser), .s_data_axis_tvalid(s_data_axis_tvalid),
    .s_data_axis_tready(s_data_axis_tready), .s_data_axis_tlast(s_data_axis_tlast),
    .s_ctrl_axis_tdata(s_ctrl_axis_tdata), .s_ctrl_axis_tkeep(s_ctrl_axis_tkeep),
    .s_ctrl_axis_tuser(s_ctrl_axis_tuser), .s_ctrl_axis_tvalid(s_ctrl_axis_tvalid),
    .s_ctrl_axis_tready(s_ctrl_axis_tready), .s_ctrl_axis_tlast(s_ctrl_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tsrc(m_axis_tsrc), .data_pause(data_pause), .busy(busy),
    .ctrl_pkt_cnt(ctrl_pkt_cnt), .data_pkt_cnt(data_pkt_cnt)
  );

  // Narrow-counter instance shares stimulus so counter wrap is visible quickly.
  menshen_ctrl_data_sched #(.MAX_CTRL_BURST(MAXB), .CNT_WIDTH(4)) dut_w4 (
    .clk(clk), .rst(rst),
    .s_data_axis_tdata(s_data_axis_tdata), .s_data_axis_tkeep(s_data_axis_tkeep),
    .s_data_axis_tuser(s_data_axis_tuser), .s_data_axis_tvalid(s_data_axis_tvalid),
    .s_data_axis_tready(w_d_tready), .s_data_axis_tlast(s_data_axis_tlast),
    .s_ctrl_axis_tdata(s_ctrl_axis_tdata), .s_ctrl_axis_tkeep(s_ctrl_axis_tkeep),
    .s_ctrl_axis_tuser(s_ctrl_axis_tuser), .s_ctrl_axis_tvalid(s_ctrl_axis_tvalid),
    .s_ctrl_axis_tready(w_c_tready), .s_ctrl_axis_tlast(s_ctrl_axis_tlast),
    .m_axis_tdata(w_tdata), .m_axis_tkeep(w_tkeep), .m_axis_tuser(w_tuser),
    .m_axis_tvalid(w_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(w_tlast),
    .m_axis_tsrc(w_tsrc), .data_pause(data_pause), .busy(w_busy),
    .ctrl_pkt_cnt(w_ccnt), .data_pkt_cnt(w_dcnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    bit cv, dv, pz, mr;
    bit ev, esrc, ecr, edr, ebusy;
    int edc;
  } vec_t;

  beat_t cq[$];
  beat_t dq[$];
  bit c_hold = 0, d_hold = 0, c_en = 1, d_en = 1, rand_gap = 0;

  // Reference model: who owns the output (0 none, 1 ctrl, 2 data), burst and packet counts.
  int owner = 0;
  int burst = 0;
  int unsigned ccnt = 0, dcnt = 0;
  int cyc = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_pkt(input bit ctrl, input int nbeats, input logic [KW-1:0] last_keep);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.d = rand_data();
      b.k = (i == nbeats - 1) ? last_keep : '1;
      b.u = {$urandom, $urandom, $urandom, $urandom};
      b.l = (i == nbeats - 1);
      if (ctrl) cq.push_back(b);
      else      dq.push_back(b);
    end
  endtask

  task automatic drive();
    if (!c_hold) begin
      if (c_en && cq.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
        s_ctrl_axis_tdata = cq[0].d; s_ctrl_axis_tkeep = cq[0].k;
        s_ctrl_axis_tuser = cq[0].u; s_ctrl_axis_tlast = cq[0].l;
        s_ctrl_axis_tvalid = 1'b1; c_hold = 1;
      end else s_ctrl_axis_tvalid = 1'b0;
    end
    if (!d_hold) begin
      if (d_en && dq.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
        s_data_axis_tdata = dq[0].d; s_data_axis_tkeep = dq[0].k;
        s_data_axis_tuser = dq[0].u; s_data_axis_tlast = dq[0].l;
        s_data_axis_tvalid = 1'b1; d_hold = 1;
      end else s_data_axis_tvalid = 1'b0;
    end
  endtask

  task automatic check_model();
    logic ev;
    logic [3:0] c4, d4;
    ev = (owner == 1) ? s_ctrl_axis_tvalid : ((owner == 2) ? s_data_axis_tvalid : 1'b0);
    c4 = ccnt[3:0];
    d4 = dcnt[3:0];
    chk("m_tvalid", m_axis_tvalid, ev);
    chk("ctrl_tready", s_ctrl_axis_tready, owner == 1 && m_axis_tready);
    chk("data_tready", s_data_axis_tready, owner == 2 && m_axis_tready);
    chk("m_tsrc", m_axis_tsrc, owner == 1);
    chk("busy", busy, owner != 0);
    if (owner == 1) begin
      chk("m_tdata_ctrl", m_axis_tdata, s_ctrl_axis_tdata);
      chk("m_tkeep_ctrl", m_axis_tkeep, s_ctrl_axis_tkeep);
      chk("m_tuser_ctrl", m_axis_tuser, s_ctrl_axis_tuser);
      chk("m_tlast_ctrl", m_axis_tlast, s_ctrl_axis_tlast);
    end else if (owner == 2) begin
      chk("m_tdata_data", m_axis_tdata, s_data_axis_tdata);
      chk("m_tkeep_data", m_axis_tkeep, s_data_axis_tkeep);
      chk("m_tuser_data", m_axis_tuser, s_data_axis_tuser);
      chk("m_tlast_data", m_axis_tlast, s_data_axis_tlast);
    end
    chk("ctrl_pkt_cnt", ctrl_pkt_cnt, ccnt);
    chk("data_pkt_cnt", data_pkt_cnt, dcnt);
    chk("w4_tvalid", w_tvalid, ev);
    chk("w4_ctrl_cnt", w_ccnt, c4);
    chk("w4_data_cnt", w_dcnt, d4);
  endtask

  task automatic step_pre();
    drive();
    #1;
    check_model();
  endtask

  task automatic step_post();
    bit c_acc, d_acc, data_ok;
    int n_owner, n_burst;
    int unsigned n_c, n_d;
    c_acc = s_ctrl_axis_tvalid && s_ctrl_axis_tready;
    d_acc = s_data_axis_tvalid && s_data_axis_tready;
    n_owner = owner; n_burst = burst; n_c = ccnt; n_d = dcnt;
    if (rst) begin
      n_owner = 0; n_burst = 0; n_c = 0; n_d = 0;
    end else if (owner == 0) begin
      data_ok = s_data_axis_tvalid && !data_pause;
      if (s_ctrl_axis_tvalid && !(burst >= MAXB && data_ok)) n_owner = 1;
      else if (data_ok)                                       n_owner = 2;
    end else if (owner == 1 && s_ctrl_axis_tvalid && m_axis_tready && s_ctrl_axis_tlast) begin
      n_owner = 0;
      n_c = ccnt + 1;
      n_burst = s_data_axis_tvalid ? ((burst < 15) ? burst + 1 : 15) : 0;
    end else if (owner == 2 && s_data_axis_tvalid && m_axis_tready && s_data_axis_tlast) begin
      n_owner = 0;
      n_d = dcnt + 1;
      n_burst = 0;
    end
    @(posedge clk);
    owner = n_owner; burst = n_burst; ccnt = n_c; dcnt = n_d;
    cyc++;
    if (rst) begin
      cq.delete(); dq.delete();
      c_hold = 0; d_hold = 0;
      s_ctrl_axis_tvalid = 1'b0; s_data_axis_tvalid = 1'b0;
    end else begin
      if (c_acc) begin void'(cq.pop_front()); c_hold = 0; end
      if (d_acc) begin void'(dq.pop_front()); d_hold = 0; end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_pre();
    step_post();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[24];
    int last_d, first_c, dbeats, k;
    bit pushed;

    for (int i = 0; i < 24; i++) begin
      tab[i].cv = 1; tab[i].dv = (i < 20); tab[i].pz = 0; tab[i].mr = 1;
      tab[i].ev = (i % 2 == 1);
      tab[i].edr = (i % 10 == 9) && (i < 20);
      tab[i].esrc = tab[i].ev && !tab[i].edr;
      tab[i].ecr = tab[i].esrc;
      tab[i].ebusy = tab[i].ev;
      tab[i].edc = (i < 10) ? 0 : ((i < 20) ? 1 : 2);
    end

    @(negedge clk);
    do_reset();
    step_pre();
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_ctrl_tready", s_ctrl_axis_tready, 1'b0);
    chk("rst_data_tready", s_data_axis_tready, 1'b0);
    chk("rst_tsrc", m_axis_tsrc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    step_post();

    // Two-beat control packet with a partial last beat
    push_pkt(1, 2, 64'h0000000000000003);
    step_pre();
    chk("ctrl2_bubble", m_axis_tvalid, 1'b0);
    step_post();
    step_pre();
    chk("ctrl2_first_xfer", {m_axis_tvalid, m_axis_tsrc, m_axis_tlast}, 3'b110);
    step_post();
    step_pre();
    chk("ctrl2_last", {m_axis_tvalid, m_axis_tsrc, m_axis_tlast}, 3'b111);
    chk("ctrl2_keep", m_axis_tkeep, 64'h0000000000000003);
    step_post();
    step_pre();
    chk("ctrl2_cnt", ctrl_pkt_cnt, 32'd1);
    step_post();

    // Burst-limit vectors: both sources saturated with single-beat packets
    do_reset();
    for (int i = 0; i < 12; i++) push_pkt(1, 1, '1);
    for (int i = 0; i < 3; i++)  push_pkt(0, 1, '1);
    for (int i = 0; i < 24; i++) begin
      c_en = tab[i].cv; d_en = tab[i].dv; data_pause = tab[i].pz; m_axis_tready = tab[i].mr;
      step_pre();
      chk("tab_valid", m_axis_tvalid, tab[i].ev);
      chk("tab_src", m_axis_tsrc, tab[i].esrc);
      chk("tab_ctrl_ready", s_ctrl_axis_tready, tab[i].ecr);
      chk("tab_data_ready", s_data_axis_tready, tab[i].edr);
      chk("tab_busy", busy, tab[i].ebusy);
      chk("tab_data_cnt", data_pkt_cnt, tab[i].edc);
      step_post();
    end
    c_en = 1; d_en = 1;

    // data_pause holds off a waiting data packet
    do_reset();
    data_pause = 1'b1;
    push_pkt(0, 1, '1);
    for (int i = 0; i < 20; i++) begin
      step_pre();
      chk("pause_data_ready", s_data_axis_tready, 1'b0);
      chk("pause_busy", busy, 1'b0);
      chk("pause_valid", m_axis_tvalid, 1'b0);
      step_post();
    end
    data_pause = 1'b0;
    step_pre();
    chk("pause_release_bubble", m_axis_tvalid, 1'b0);
    step_post();
    step_pre();
    chk("pause_release_grant", {m_axis_tvalid, m_axis_tsrc}, 2'b10);
    step_post();
    for (int i = 0; i < 2; i++) begin step_pre(); step_post(); end

    // Backpressured 3-beat data packet; control arrives mid-packet
    do_reset();
    push_pkt(0, 3, '1);
    last_d = -100; first_c = -1; dbeats = 0; pushed = 0;
    for (int i = 0; i < 30; i++) begin
      m_axis_tready = (i % 2 == 0);
      step_pre();
      if (m_axis_tvalid && m_axis_tsrc && first_c < 0) first_c = cyc;
      if (m_axis_tvalid && m_axis_tready && !m_axis_tsrc && first_c < 0) begin
        dbeats++;
        if (m_axis_tlast) last_d = cyc;
      end
      step_post();
      if (!pushed && dbeats > 0) begin push_pkt(1, 2, '1); pushed = 1; end
    end
    m_axis_tready = 1'b1;
    chk("bp_data_beats", dbeats, 3);
    chk("bp_ctrl_gap", first_c - last_d, 2);

    // Reset in the middle of a 3-beat control packet
    push_pkt(1, 3, '1);
    step_pre(); step_post();
    step_pre(); step_post();
    rst = 1'b1;
    step_pre();
    step_post();
    rst = 1'b0;
    push_pkt(0, 1, '1);
    step_pre();
    chk("midrst_valid", m_axis_tvalid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ccnt", ctrl_pkt_cnt, 32'd0);
    chk("midrst_dcnt", data_pkt_cnt, 32'd0);
    step_post();
    step_pre();
    chk("midrst_fresh_grant", {m_axis_tvalid, m_axis_tsrc}, 2'b10);
    step_post();
    step_pre(); step_post();

    // Narrow counter wrap after 17 data packets
    do_reset();
    for (int i = 0; i < 17; i++) push_pkt(0, 1, '1);
    k = 0;
    while (k < 80 && !(dq.size() == 0 && owner == 0)) begin
      step_pre(); step_post(); k++;
    end
    step_pre();
    chk("wrap_w4_dcnt", w_dcnt, 4'd1);
    chk("wrap_dcnt", data_pkt_cnt, 32'd17);
    step_post();

    // Randomized traffic against the reference model
    do_reset();
    rand_gap = 1;
    for (int i = 0; i < 4000; i++) begin
      if (cq.size() < 4 && $urandom_range(0, 2) != 0)
        push_pkt(1, $urandom_range(1, 4), {$urandom, $urandom});
      if (dq.size() < 4 && $urandom_range(0, 3) == 0)
        push_pkt(0, $urandom_range(1, 4), {$urandom, $urandom});
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) data_pause = ~data_pause;
      step_pre();
      step_post();
    end
    rand_gap = 0; data_pause = 1'b0; m_axis_tready = 1'b1;
    for (int i = 0; i < 200; i++) begin step_pre(); step_post(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
